// File: rtl/syx_write_parser_pkg.sv
// Shared definitions for the SysEx parameter-write parser: parser states,
// MIDI byte constants and the write record handed to the pulse generator.
package syx_write_parser_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_BANK,
        S_ADR,
        S_DHI,
        S_DLO,
        S_WAIT_EOX
    } state_t;

    localparam logic [7:0] MIDI_SOX     = 8'hF0;
    localparam logic [7:0] MIDI_EOX     = 8'hF7;
    localparam logic [7:0] MIDI_RT_BASE = 8'hF8;
    localparam logic [7:0] NUM_BANKS    = 8'd6;

    typedef struct packed {
        logic [2:0] bank;
        logic [6:0] adr;
        logic [7:0] data;
    } write_t;

endpackage

// File: rtl/syx_write_parser_pulse_gen.sv
// syx_pulse_gen: stretches each completed write into a PULSE_LEN-cycle strobe
// and holds at most one overlapping write until the strobe has been low a cycle.
module syx_pulse_gen
    import syx_write_parser_pkg::*;
#(
    parameter int PULSE_LEN = 6
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   wr_valid,
    input  write_t wr,
    output logic   data_ready,
    output write_t cur,
    output logic   drop
);

    localparam logic [3:0] LAST_CNT = 4'(PULSE_LEN - 1);

    logic [3:0] cnt;
    logic       pend_valid;
    write_t     pend;

    assign drop = wr_valid && data_ready && pend_valid;

    // NOTE: every register here resets asynchronously and updates with <= only,
    // so a reset mid-pulse kills data_ready and the pending entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_ready <= 1'b0;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend       <= '0;
            cur        <= '0;
        end else if (data_ready) begin
            if (cnt == 4'd0) data_ready <= 1'b0;
            else             cnt        <= cnt - 4'd1;
            if (wr_valid && !pend_valid) begin
                pend       <= wr;
                pend_valid <= 1'b1;
            end
        end else if (pend_valid) begin
            // First low cycle after a pulse: launch the held write.
            data_ready <= 1'b1;
            cnt        <= LAST_CNT;
            cur        <= pend;
            if (wr_valid) pend       <= wr;
            else          pend_valid <= 1'b0;
        end else if (wr_valid) begin
            data_ready <= 1'b1;
            cnt        <= LAST_CNT;
            cur        <= wr;
        end
    end

endmodule

// File: rtl/syx_write_parser.sv
// SysEx parameter-write parser: F0 <id> <bank> <adr> <hi> <lo> ... F7.
// Define SYX_AUTOINC_EN to accept further hi/lo pairs at consecutive addresses.
module syx_write_parser
    import syx_write_parser_pkg::*;
#(
    parameter logic [7:0] SYX_ID    = 8'h7D,
    parameter int         PULSE_LEN = 6
) (
    input  logic       CLOCK_25,
    input  logic       reset_reg_N,
    input  logic [7:0] midi_byte,
    input  logic       midi_byte_rdy,
    output logic [2:0] bank_adr,
    output logic [6:0] adr,
    output logic [7:0] out_data,
    output logic       data_ready,
    output logic       busy,
    output logic       syx_err
);

    state_t     state;
    logic [2:0] bank;
    logic [6:0] wr_adr;
    logic       val_hi;
    logic       wr_valid;
    logic       wr_drop;
    write_t     wr;
    write_t     cur;

    // The write leaves in the DLO strobe cycle so the strobe rises one cycle later.
    assign wr_valid = midi_byte_rdy && (state == S_DLO) && !midi_byte[7];
    assign wr       = {bank, wr_adr, val_hi, midi_byte[6:0]};

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            syx_err <= 1'b0;
            bank    <= '0;
            wr_adr  <= '0;
            val_hi  <= 1'b0;
        end else begin
            if (midi_byte_rdy) begin
                if (midi_byte >= MIDI_RT_BASE) begin
                    // real-time bytes pass through without touching the parse
                end else if (midi_byte == MIDI_SOX) begin
                    state   <= S_ID;
                    busy    <= 1'b1;
                    syx_err <= 1'b0;
                end else if (state == S_IDLE) begin
                    // outside a message everything but F0 is ignored
                end else if (midi_byte == MIDI_EOX) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else if (midi_byte[7]) begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    syx_err <= 1'b1;
                end else begin
                    case (state)
                        S_ID: state <= (midi_byte == SYX_ID) ? S_BANK : S_WAIT_EOX;
                        S_BANK: begin
                            if (midi_byte < NUM_BANKS) begin
                                bank  <= midi_byte[2:0];
                                state <= S_ADR;
                            end else begin
                                state   <= S_WAIT_EOX;
                                syx_err <= 1'b1;
                            end
                        end
                        S_ADR: begin
                            wr_adr <= midi_byte[6:0];
                            state  <= S_DHI;
                        end
                        S_DHI: begin
                            val_hi <= midi_byte[0];
                            state  <= S_DLO;
                        end
                        S_DLO: begin
`ifdef SYX_AUTOINC_EN
                            wr_adr <= wr_adr + 7'd1;
                            state  <= S_DHI;
`else
                            state  <= S_WAIT_EOX;
`endif
                        end
                        default: state <= state;
                    endcase
                end
            end
            if (wr_drop) syx_err <= 1'b1;
        end
    end

    syx_pulse_gen #(
        .PULSE_LEN(PULSE_LEN)
    ) u_pulse_gen (
        .clk       (CLOCK_25),
        .rst_n     (reset_reg_N),
        .wr_valid  (wr_valid),
        .wr        (wr),
        .data_ready(data_ready),
        .cur       (cur),
        .drop      (wr_drop)
    );

    assign bank_adr = cur.bank;
    assign adr      = cur.adr;
    assign out_data = cur.data;

endmodule

// File: tb/tb_syx_write_parser.sv
// Directed bench for syx_write_parser; a second instance with a 15-cycle pulse
// exercises the pending-buffer overflow path.
module tb_syx_write_parser;

    typedef logic [7:0] bytes_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] midi_byte = 8'h00;
    logic       midi_byte_rdy = 1'b0;

    logic [2:0] bank_adr, l_bank_adr;
    logic [6:0] adr, l_adr;
    logic [7:0] out_data, l_out_data;
    logic       data_ready, l_data_ready;
    logic       busy, l_busy;
    logic       syx_err, l_syx_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [17:0] wq[$];
    int          lq[$];
    int          gq[$];
    logic        prev_dr = 1'b0;
    int          cur_len = 0;
    int          low_cnt = 0;
    logic [17:0] cur_w = '0;
    bytes_t      msg;

    always #20 clk = ~clk;

    syx_write_parser u_dut (
        .CLOCK_25     (clk),
        .reset_reg_N  (rst_n),
        .midi_byte    (midi_byte),
        .midi_byte_rdy(midi_byte_rdy),
        .bank_adr     (bank_adr),
        .adr          (adr),
        .out_data     (out_data),
        .data_ready   (data_ready),
        .busy         (busy),
        .syx_err      (syx_err)
    );

    syx_write_parser #(
        .PULSE_LEN(15)
    ) u_dut_long (
        .CLOCK_25     (clk),
        .reset_reg_N  (rst_n),
        .midi_byte    (midi_byte),
        .midi_byte_rdy(midi_byte_rdy),
        .bank_adr     (l_bank_adr),
        .adr          (l_adr),
        .out_data     (l_out_data),
        .data_ready   (l_data_ready),
        .busy         (l_busy),
        .syx_err      (l_syx_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        midi_byte     = b;
        midi_byte_rdy = 1'b1;
        @(negedge clk);
        midi_byte_rdy = 1'b0;
    endtask

    task automatic send_msg(input bytes_t m);
        foreach (m[i]) send_byte(m[i]);
    endtask

    task automatic send_fast(input bytes_t m);
        foreach (m[i]) begin
            @(negedge clk);
            midi_byte     = m[i];
            midi_byte_rdy = 1'b1;
        end
        @(negedge clk);
        midi_byte_rdy = 1'b0;
    endtask

    task automatic clear_mon();
        wq.delete();
        lq.delete();
        gq.delete();
    endtask

    function automatic logic [17:0] get_w(input int i);
        return (wq.size() > i) ? wq[i] : 18'h3FFFF;
    endfunction

    function automatic int get_i(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    // Records every strobe of the main instance: payload, high length, preceding low gap.
    always @(negedge clk) begin
        if (data_ready) begin
            if (!prev_dr) begin
                cur_w = {bank_adr, adr, out_data};
                wq.push_back(cur_w);
                gq.push_back(low_cnt);
                cur_len = 1;
            end else begin
                cur_len++;
                check("stable_outputs", {bank_adr, adr, out_data}, cur_w);
            end
        end else begin
            if (prev_dr) lq.push_back(cur_len);
            low_cnt = prev_dr ? 1 : low_cnt + 1;
        end
        prev_dr = data_ready;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_syx_err", syx_err, 1'b0);
        check("rst_outputs", {bank_adr, adr, out_data}, 18'h0);
        check("rst_long_data_ready", l_data_ready, 1'b0);
        rst_n = 1'b1;

        // Basic single write; F0 is the very first strobe after reset release.
        send_byte(8'hF0);
        check("busy_after_f0", busy, 1'b1);
        msg = {8'h7D, 8'h02, 8'h10, 8'h01};
        send_msg(msg);
        check("dr_before_dlo", data_ready, 1'b0);
        send_byte(8'h23);
        check("dr_latency", data_ready, 1'b1);
        send_byte(8'hF7);
        check("busy_after_f7", busy, 1'b0);
        repeat (20) @(negedge clk);
        check("basic_count", wq.size(), 1);
        check("basic_write", get_w(0), {3'd2, 7'h10, 8'hA3});
        check("basic_len", get_i(lq, 0), 6);
        check("basic_err", syx_err, 1'b0);

        // Address wrap / one-pair-per-message behaviour.
        clear_mon();
        msg = {8'hF0, 8'h7D, 8'h01, 8'h7F, 8'h00, 8'h05, 8'h00, 8'h06, 8'hF7};
        send_msg(msg);
        repeat (20) @(negedge clk);
        check("multi_w0", get_w(0), {3'd1, 7'h7F, 8'h05});
`ifdef SYX_AUTOINC_EN
        check("multi_count", wq.size(), 2);
        check("multi_w1", get_w(1), {3'd1, 7'h00, 8'h06});
        check("multi_gap", get_i(gq, 1), 1);
        check("multi_len1", get_i(lq, 1), 6);
`else
        check("multi_count", wq.size(), 1);
`endif

        // Real-time bytes interleaved.
        clear_mon();
        msg = {8'hF0, 8'h7D, 8'h03, 8'hF8, 8'h20, 8'hFE, 8'h00, 8'h11, 8'hF7};
        send_msg(msg);
        repeat (20) @(negedge clk);
        check("rt_count", wq.size(), 1);
        check("rt_write", get_w(0), {3'd3, 7'h20, 8'h11});

        // Unexpected status byte aborts with error.
        clear_mon();
        msg = {8'hF0, 8'h7D, 8'h01, 8'h90};
        send_msg(msg);
        check("status_err", syx_err, 1'b1);
        check("status_busy", busy, 1'b0);

        // Bad bank, then recovery by a valid message.
        msg = {8'hF0, 8'h7D, 8'h07, 8'h00, 8'h00, 8'hF7};
        send_msg(msg);
        check("bank_err", syx_err, 1'b1);
        send_byte(8'hF0);
        check("err_cleared", syx_err, 1'b0);
        msg = {8'h7D, 8'h04, 8'h01, 8'h00, 8'h7F, 8'hF7};
        send_msg(msg);
        repeat (20) @(negedge clk);
        check("recover_count", wq.size(), 1);
        check("recover_write", get_w(0), {3'd4, 7'h01, 8'h7F});

        // Back-to-back writes via restart: held write, and overflow on the long instance.
        clear_mon();
        msg = {8'hF0, 8'h7D, 8'h05, 8'h11, 8'h00, 8'h22,
               8'hF0, 8'h7D, 8'h05, 8'h12, 8'h01, 8'h33,
               8'hF0, 8'h7D, 8'h05, 8'h13, 8'h00, 8'h44, 8'hF7};
        send_fast(msg);
        repeat (40) @(negedge clk);
        check("burst_count", wq.size(), 3);
        check("burst_w0", get_w(0), {3'd5, 7'h11, 8'h22});
        check("burst_w1", get_w(1), {3'd5, 7'h12, 8'hB3});
        check("burst_w2", get_w(2), {3'd5, 7'h13, 8'h44});
        check("burst_gap1", get_i(gq, 1), 1);
        check("burst_gap2", get_i(gq, 2), 1);
        check("burst_len0", get_i(lq, 0), 6);
        check("burst_len1", get_i(lq, 1), 6);
        check("burst_err", syx_err, 1'b0);
        check("drop_err", l_syx_err, 1'b1);
        check("drop_last_write", {l_bank_adr, l_adr, l_out_data}, {3'd5, 7'h12, 8'hB3});
        check("drop_dr_low", l_data_ready, 1'b0);

        // Reset in pulse cycle 3.
        clear_mon();
        msg = {8'hF0, 8'h7D, 8'h02, 8'h30, 8'h00, 8'h44};
        send_msg(msg);
        check("pre_reset_dr", data_ready, 1'b1);
        repeat (2) @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        check("async_dr", data_ready, 1'b0);
        check("async_outputs", {bank_adr, adr, out_data}, 18'h0);
        check("async_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        send_byte(8'hF0);
        check("first_byte_after_reset", busy, 1'b1);
        send_byte(8'hF7);
        repeat (20) @(negedge clk);
        check("no_reissue", wq.size(), 0);
        check("post_reset_dr", data_ready, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/syx_write_parser.md
SYX_WRITE_PARSER -- requirements
Module: syx_write_parser

Interface
REQ-001 Parameter SYX_ID, default 8'h7D, manufacturer ID byte accepted after F0.
REQ-002 Parameter PULSE_LEN, default 6, data_ready high time in clock cycles; legal range 4..15.
REQ-003 CLOCK_25  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset_reg_N  in  1  reset, asynchronous assert, active-low.
REQ-005 midi_byte  in  8  received MIDI byte, valid when midi_byte_rdy is high.
REQ-006 midi_byte_rdy  in  1  one-cycle strobe, one byte per strobe.
REQ-007 bank_adr  out  3  bank number of current write, 0..5.
REQ-008 adr  out  7  parameter address within bank.
REQ-009 out_data  out  8  parameter value.
REQ-010 data_ready  out  1  write strobe, high PULSE_LEN cycles; bank_adr/adr/out_data stable throughout.
REQ-011 busy  out  1  high from F0 accepted until return to IDLE.
REQ-012 syx_err  out  1  sticky error flag, cleared on next accepted F0.

Function
REQ-013 States: IDLE, ID, BANK, ADR, DHI, DLO, WAIT_EOX; one byte consumed per midi_byte_rdy.
REQ-014 IDLE: F0 -> ID; all other bytes ignored.
REQ-015 ID: SYX_ID -> BANK; other data byte -> WAIT_EOX, no error.
REQ-016 BANK: value 0..5 -> ADR; 6..7F -> WAIT_EOX, syx_err set.
REQ-017 ADR: latch 7-bit address -> DHI.
REQ-018 DHI: bit0 latched as value bit7 -> DLO; DLO: byte[6:0] as value bits6:0, write issued.
REQ-019 After DLO: with auto-increment compiled in, address+1 (wraps 7F->00) and -> DHI; otherwise -> WAIT_EOX.
REQ-020 F7 in any non-IDLE state -> IDLE; F7 between DHI and DLO discards the half pair.
REQ-021 Real-time bytes F8..FF ignored in every state, no state change.
REQ-022 Any other status byte (80..EF, F1..F6) outside IDLE -> IDLE, syx_err set; F0 -> ID (restart).
REQ-023 Write issue latency: data_ready rises the cycle after the DLO strobe.
REQ-024 One-entry pending buffer: write completing while data_ready high is held, issued after data_ready has been low for exactly 1 cycle.
REQ-025 Write completing while the pending buffer is full is dropped and syx_err set.
REQ-026 Outputs never change while data_ready is high.

Reset
REQ-027 Reset asserted: state IDLE, pulse counter 0, pending empty, all outputs 0.
REQ-028 Reset mid-pulse terminates data_ready immediately; no write reissued after release.
REQ-029 First byte accepted on the first midi_byte_rdy after reset release.

Configuration
REQ-030 Macro SYX_AUTOINC_EN: defined -> REQ-019 auto-increment multi-pair writes; undefined -> one pair per message, remaining data bytes ignored until F7.

Structure
REQ-031 Shared package holds state enumeration, MIDI constants (F0, F7, real-time base F8) and NUM_BANKS=6.
REQ-032 One sub-module syx_pulse_gen: pulse counter plus pending buffer (REQ-023..026).

Verification
REQ-033 F0 7D 02 10 01 23 F7 -> one write bank 2, adr 10, data A3, data_ready high 6 cycles.
REQ-034 F0 7D 01 7F 00 05 00 06 F7 with SYX_AUTOINC_EN -> writes (1,7F,05),(1,00,06); without -> only first.
REQ-035 F0 7D 03 F8 20 FE 00 11 F7 -> single write bank 3, adr 20, data 11; real-time bytes ignored.
REQ-036 F0 7D 07 ... F7 -> no write, syx_err=1; following valid F0 message clears syx_err and writes.
REQ-037 Pairs spaced 2 cycles apart -> second write held, rises after 1 low cycle; third overlapping -> dropped, syx_err=1.
REQ-038 reset_reg_N low at pulse cycle 3 -> data_ready 0 asynchronously, all outputs 0, no write after release.
